// File: rtl/pipe_stage_chain_if.sv
// Handshake bundle for pipe_stage_chain: producer side (in_*) and consumer side (out_*).
interface pipe_stage_chain_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Multi-stage pipeline register chain with per-stage stall/flush, bubble insertion
// and saturating bubble/flush performance counters.
module pipe_stage_chain #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      STAGES  = 2,
  parameter logic [WIDTH-1:0] CLR_VAL = '0,
  parameter int unsigned      COUNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  pipe_stage_chain_if.slave   bus,
  input  logic [STAGES-1:0]   stall,
  input  logic [STAGES-1:0]   flush,
  input  logic                clr_cnt,
  output logic [STAGES-1:0]   stage_valid,
  output logic [COUNT_W-1:0]  bubble_cnt,
  output logic [COUNT_W-1:0]  flush_cnt
);

  localparam int unsigned KILL_W = $clog2(STAGES + 1);
  localparam int unsigned SUM_W  = COUNT_W + KILL_W;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [STAGES-1:0] hold;
  logic [WIDTH-1:0]  stageData [STAGES];
  logic [STAGES-1:0] stageValid;

  // A stage holds if it or any downstream stage is stalled.
  for (genvar g = 0; g < STAGES; g++) begin : gHold
    assign hold[g] = |stall[STAGES-1:g];
  end

  assign bus.in_ready = ~hold[0];

  for (genvar g = 0; g < STAGES; g++) begin : gStage
    logic [WIDTH-1:0] dataQ;
    logic             validQ;
    logic [WIDTH-1:0] prevData;
    logic             prevValid;
    logic             prevHold;

    if (g == 0) begin : gHead
      assign prevData  = bus.in_valid ? bus.in_data : CLR_VAL;
      assign prevValid = bus.in_valid;
      assign prevHold  = 1'b0;
    end else begin : gBody
      assign prevData  = stageData[g-1];
      assign prevValid = stageValid[g-1];
      assign prevHold  = hold[g-1];
    end

    // Priority: reset, flush, hold, then advance (bubble if upstream is held).
    always_ff @(posedge clk) begin
      if (!reset) begin
        dataQ  <= CLR_VAL;
        validQ <= 1'b0;
      end else if (flush[g]) begin
        dataQ  <= CLR_VAL;
        validQ <= 1'b0;
      end else if (!hold[g]) begin
        if (prevHold) begin
          dataQ  <= CLR_VAL;
          validQ <= 1'b0;
        end else begin
          dataQ  <= prevData;
          validQ <= prevValid;
        end
      end
    end

    assign stageData[g]  = dataQ;
    assign stageValid[g] = validQ;
  end

  assign stage_valid   = stageValid;
  assign bus.out_data  = stageData[STAGES-1];
  assign bus.out_valid = stageValid[STAGES-1];

  logic [KILL_W-1:0]  killCount;
  logic [SUM_W-1:0]   flushSum;
  logic [COUNT_W-1:0] flushNext;
  logic [COUNT_W-1:0] bubbleNext;

  // Saturating next values; the flush sum is widened so it can never wrap.
  always_comb begin
    killCount  = KILL_W'($countones(flush & stageValid));
    flushSum   = SUM_W'(flush_cnt) + SUM_W'(killCount);
    flushNext  = (flushSum > SUM_W'(CNT_MAX)) ? CNT_MAX : flushSum[COUNT_W-1:0];
    bubbleNext = bubble_cnt;
    if (!stageValid[STAGES-1] && (bubble_cnt != CNT_MAX)) begin
      bubbleNext = bubble_cnt + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (clr_cnt) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      bubble_cnt <= bubbleNext;
      flush_cnt  <= flushNext;
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed, table-driven bench for pipe_stage_chain (WIDTH=8, STAGES=3, COUNT_W=4).
module tb_pipe_stage_chain;

  localparam int unsigned W  = 8;
  localparam int unsigned S  = 3;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic [S-1:0]  stall;
  logic [S-1:0]  flush;
  logic          clrCnt;
  logic [S-1:0]  stageValid;
  logic [CW-1:0] bubbleCnt;
  logic [CW-1:0] flushCnt;

  pipe_stage_chain_if #(.WIDTH(W)) bus ();

  pipe_stage_chain #(
    .WIDTH   (W),
    .STAGES  (S),
    .CLR_VAL ('0),
    .COUNT_W (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .stall       (stall),
    .flush       (flush),
    .clr_cnt     (clrCnt),
    .stage_valid (stageValid),
    .bubble_cnt  (bubbleCnt),
    .flush_cnt   (flushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          inValid;
    logic [W-1:0]  inData;
    logic [S-1:0]  stall;
    logic [S-1:0]  flush;
    logic          clr;
    logic          expReady;
    logic [S-1:0]  expSv;
    logic [W-1:0]  expOut;
    logic [CW-1:0] expBub;
    logic [CW-1:0] expFl;
  } vec_t;

  int compared   = 0;
  int mismatched = 0;

  function automatic vec_t mk(input logic rst, input logic inV, input logic [W-1:0] d,
                              input logic [S-1:0] st, input logic [S-1:0] fl, input logic clr,
                              input logic rdy, input logic [S-1:0] sv, input logic [W-1:0] od,
                              input logic [CW-1:0] bub, input logic [CW-1:0] fc);
    vec_t v;
    v.rst = rst; v.inValid = inV; v.inData = d; v.stall = st; v.flush = fl; v.clr = clr;
    v.expReady = rdy; v.expSv = sv; v.expOut = od; v.expBub = bub; v.expFl = fc;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s [step %0d]: got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic inV, input logic [W-1:0] d,
                       input logic [S-1:0] st, input logic [S-1:0] fl, input logic clr);
    reset = rst; bus.in_valid = inV; bus.in_data = d; stall = st; flush = fl; clrCnt = clr;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs, check in_ready before the edge and all state after it.
  task automatic applyVec(input vec_t v, input int idx);
    reset = v.rst; bus.in_valid = v.inValid; bus.in_data = v.inData;
    stall = v.stall; flush = v.flush; clrCnt = v.clr;
    #1;
    check("in_ready", idx, 32'(bus.in_ready), 32'(v.expReady));
    @(posedge clk);
    #1;
    check("stage_valid", idx, 32'(stageValid), 32'(v.expSv));
    check("out_data", idx, 32'(bus.out_data), 32'(v.expOut));
    check("out_valid", idx, 32'(bus.out_valid), 32'(v.expSv[S-1]));
    check("bubble_cnt", idx, 32'(bubbleCnt), 32'(v.expBub));
    check("flush_cnt", idx, 32'(flushCnt), 32'(v.expFl));
  endtask

  vec_t vecs[22];

  initial begin
    int step;
    int e;

    // rst inV data stall flush clr | ready sv out bub fl
    vecs[0]  = mk(0, 1, 8'hA5, 3'b000, 3'b000, 0, 1, 3'b000, 8'h00, 4'd0,  4'd0);
    vecs[1]  = mk(0, 1, 8'hA5, 3'b000, 3'b000, 0, 1, 3'b000, 8'h00, 4'd0,  4'd0);
    vecs[2]  = mk(1, 1, 8'h01, 3'b000, 3'b000, 0, 1, 3'b001, 8'h00, 4'd1,  4'd0);
    vecs[3]  = mk(1, 1, 8'h02, 3'b000, 3'b000, 0, 1, 3'b011, 8'h00, 4'd2,  4'd0);
    vecs[4]  = mk(1, 1, 8'h03, 3'b000, 3'b000, 0, 1, 3'b111, 8'h01, 4'd3,  4'd0);
    vecs[5]  = mk(1, 1, 8'h04, 3'b000, 3'b000, 0, 1, 3'b111, 8'h02, 4'd3,  4'd0);
    vecs[6]  = mk(1, 1, 8'h05, 3'b000, 3'b000, 0, 1, 3'b111, 8'h03, 4'd3,  4'd0);
    vecs[7]  = mk(1, 1, 8'h06, 3'b000, 3'b000, 0, 1, 3'b111, 8'h04, 4'd3,  4'd0);
    vecs[8]  = mk(1, 1, 8'h07, 3'b010, 3'b000, 0, 0, 3'b011, 8'h00, 4'd3,  4'd0);
    vecs[9]  = mk(1, 1, 8'h07, 3'b010, 3'b000, 0, 0, 3'b011, 8'h00, 4'd4,  4'd0);
    vecs[10] = mk(1, 1, 8'h07, 3'b000, 3'b000, 0, 1, 3'b111, 8'h05, 4'd5,  4'd0);
    vecs[11] = mk(1, 1, 8'h08, 3'b001, 3'b001, 0, 0, 3'b100, 8'h06, 4'd5,  4'd1);
    vecs[12] = mk(1, 1, 8'h08, 3'b000, 3'b000, 0, 1, 3'b001, 8'h00, 4'd5,  4'd1);
    vecs[13] = mk(1, 0, 8'hFF, 3'b000, 3'b000, 0, 1, 3'b010, 8'h00, 4'd6,  4'd1);
    vecs[14] = mk(1, 0, 8'hFF, 3'b000, 3'b000, 0, 1, 3'b100, 8'h08, 4'd7,  4'd1);
    vecs[15] = mk(1, 0, 8'hFF, 3'b000, 3'b000, 0, 1, 3'b000, 8'h00, 4'd7,  4'd1);
    vecs[16] = mk(1, 1, 8'h11, 3'b000, 3'b000, 0, 1, 3'b001, 8'h00, 4'd8,  4'd1);
    vecs[17] = mk(1, 1, 8'h12, 3'b000, 3'b000, 0, 1, 3'b011, 8'h00, 4'd9,  4'd1);
    vecs[18] = mk(1, 1, 8'h13, 3'b000, 3'b000, 0, 1, 3'b111, 8'h11, 4'd10, 4'd1);
    vecs[19] = mk(1, 1, 8'h14, 3'b100, 3'b010, 0, 0, 3'b101, 8'h11, 4'd10, 4'd2);
    vecs[20] = mk(1, 1, 8'h14, 3'b000, 3'b111, 0, 1, 3'b000, 8'h00, 4'd10, 4'd4);
    vecs[21] = mk(1, 1, 8'h14, 3'b000, 3'b000, 0, 1, 3'b001, 8'h00, 4'd11, 4'd4);

    step = 0;
    for (int i = 0; i < 22; i++) begin
      applyVec(vecs[i], step);
      step++;
    end

    // Bubble counter saturation after a long idle stretch.
    for (int i = 0; i < 20; i++) drive(1, 0, 8'h00, 3'b000, 3'b000, 0);
    check("bubble_sat", step, 32'(bubbleCnt), 32'hF);
    check("idle_valid", step, 32'(stageValid), 32'h0);
    step++;

    // Flush counter saturation: fill then flush the whole pipe four times.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) drive(1, 1, 8'(8'h40 + k * 3 + i), 3'b000, 3'b000, 0);
      e = 4 + 3 * (k + 1);
      if (e > 15) e = 15;
      applyVec(mk(1, 0, 8'h00, 3'b000, 3'b111, 0, 1, 3'b000, 8'h00, 4'hF, CW'(e)), step);
      step++;
    end

    // clr_cnt discards the increment of its own edge.
    applyVec(mk(1, 0, 8'h00, 3'b000, 3'b000, 1, 1, 3'b000, 8'h00, 4'd0, 4'd0), step++);
    applyVec(mk(1, 0, 8'h00, 3'b000, 3'b000, 0, 1, 3'b000, 8'h00, 4'd1, 4'd0), step++);

    // Reset in the middle of a stall, then normal resumption.
    applyVec(mk(1, 1, 8'h21, 3'b000, 3'b000, 0, 1, 3'b001, 8'h00, 4'd2, 4'd0), step++);
    applyVec(mk(1, 1, 8'h22, 3'b000, 3'b000, 0, 1, 3'b011, 8'h00, 4'd3, 4'd0), step++);
    applyVec(mk(1, 1, 8'h23, 3'b000, 3'b000, 0, 1, 3'b111, 8'h21, 4'd4, 4'd0), step++);
    applyVec(mk(1, 1, 8'h24, 3'b010, 3'b000, 0, 0, 3'b011, 8'h00, 4'd4, 4'd0), step++);
    applyVec(mk(0, 1, 8'h24, 3'b010, 3'b000, 0, 0, 3'b000, 8'h00, 4'd0, 4'd0), step++);
    applyVec(mk(1, 1, 8'h31, 3'b000, 3'b000, 0, 1, 3'b001, 8'h00, 4'd1, 4'd0), step++);
    applyVec(mk(1, 1, 8'h32, 3'b000, 3'b000, 0, 1, 3'b011, 8'h00, 4'd2, 4'd0), step++);
    applyVec(mk(1, 1, 8'h33, 3'b000, 3'b000, 0, 1, 3'b111, 8'h31, 4'd3, 4'd0), step++);
    applyVec(mk(1, 0, 8'h00, 3'b000, 3'b000, 0, 1, 3'b110, 8'h32, 4'd3, 4'd0), step++);
    applyVec(mk(1, 0, 8'h00, 3'b000, 3'b000, 0, 1, 3'b100, 8'h33, 4'd3, 4'd0), step++);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
